// File: rtl/comparador_serial_id_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   ST_IGUAL / ST_MAYOR / ST_MENOR : (p,q) state encodings of the cell chain
//   fsm_e                          : control FSM states
//   N_DEFAULT                      : default word width
package comparador_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic [1:0] ST_IGUAL = 2'b01;  // equal so far (initial state a)
  localparam logic [1:0] ST_MAYOR = 2'b10;  // A greater
  localparam logic [1:0] ST_MENOR = 2'b00;  // A smaller

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } fsm_e;

endpackage

// File: rtl/comparador_serial_id_if.sv
// Handshake/result bundle of the bit-serial comparator.
//   start, A, B                     : request side (driven by the master)
//   ready, done, P, Q, mayor, menor, igual : status/result side (driven by the slave)
interface comparador_serial_id_if #(
  parameter int N = comparador_pkg::N_DEFAULT
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ready;
  logic         done;
  logic         P;
  logic         Q;
  logic         mayor;
  logic         menor;
  logic         igual;

  modport master (
    output start, A, B,
    input  ready, done, P, Q, mayor, menor, igual
  );

  modport slave (
    input  start, A, B,
    output ready, done, P, Q, mayor, menor, igual
  );
endinterface

// File: rtl/comparador_serial_id_celda_tipica_fn.sv
// Combinational next-state function of one typical comparator cell.
// Decided states (A greater / A smaller) are absorbing; the illegal
// state 11 is mapped back to "equal so far".
//   p_i, q_i   : current state
//   ai_i, bi_i : bit of A and B at this position
//   p_o, q_o   : next state
module celda_tipica_fn
  import comparador_pkg::*;
(
  input  logic p_i,
  input  logic q_i,
  input  logic ai_i,
  input  logic bi_i,
  output logic p_o,
  output logic q_o
);

  always_comb begin
    {p_o, q_o} = ST_IGUAL;
    case ({p_i, q_i})
      ST_IGUAL: begin
        if (ai_i && !bi_i)      {p_o, q_o} = ST_MAYOR;
        else if (!ai_i && bi_i) {p_o, q_o} = ST_MENOR;
        else                    {p_o, q_o} = ST_IGUAL;
      end
      ST_MAYOR: {p_o, q_o} = ST_MAYOR;
      ST_MENOR: {p_o, q_o} = ST_MENOR;
      default:  {p_o, q_o} = ST_IGUAL;
    endcase
  end

endmodule

// File: rtl/comparador_serial_id.sv
// Bit-serial magnitude comparator: one typical cell walked MSB to LSB over
// N clocks instead of an N-cell combinational chain.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of comparador_serial_id_if (start/A/B in,
//           ready/done/P/Q/mayor/menor/igual out)
// Build option: define EARLY_EXIT_EN to finish as soon as the state is
// decided (first differing bit); otherwise latency is always N+1 cycles.
module comparador_serial_id
  import comparador_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  comparador_serial_id_if.slave  bus
);

  localparam int CW = $clog2(N);

  fsm_e          state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  sha_q,   sha_d;
  logic [N-1:0]  shb_q,   shb_d;
  logic [1:0]    pq_q,    pq_d;
  logic [1:0]    res_q,   res_d;
  logic          mayor_q, mayor_d;
  logic          menor_q, menor_d;
  logic          igual_q, igual_d;

  logic          cell_p, cell_q;
  logic          ready;
  logic          last;

  celda_tipica_fn u_celda (
    .p_i  (pq_q[1]),
    .q_i  (pq_q[0]),
    .ai_i (sha_q[N-1]),
    .bi_i (shb_q[N-1]),
    .p_o  (cell_p),
    .q_o  (cell_q)
  );

  assign ready = (state_q != RUN);

  // MSB-first absorption makes the first decided state final, so the
  // early-exit build may stop there without changing the result.
`ifdef EARLY_EXIT_EN
  assign last = (cnt_q == '0) || ({cell_p, cell_q} != ST_IGUAL);
`else
  assign last = (cnt_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    pq_d    = pq_q;
    res_d   = res_q;
    mayor_d = mayor_q;
    menor_d = menor_q;
    igual_d = igual_q;

    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (bus.start) begin
          sha_d   = bus.A;
          shb_d   = bus.B;
          pq_d    = ST_IGUAL;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        pq_d  = {cell_p, cell_q};
        sha_d = {sha_q[N-2:0], 1'b0};
        shb_d = {shb_q[N-2:0], 1'b0};
        if (last) begin
          // Results load on the edge into FIN so they are valid with done.
          state_d = FIN;
          res_d   = {cell_p, cell_q};
          mayor_d = ({cell_p, cell_q} == ST_MAYOR);
          menor_d = ({cell_p, cell_q} == ST_MENOR);
          igual_d = ({cell_p, cell_q} == ST_IGUAL);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pq_q    <= ST_IGUAL;
      res_q   <= ST_IGUAL;
      mayor_q <= 1'b0;
      menor_q <= 1'b0;
      igual_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pq_q    <= pq_d;
      res_q   <= res_d;
      mayor_q <= mayor_d;
      menor_q <= menor_d;
      igual_q <= igual_d;
    end
  end

  // Operand shifters carry data only and need no reset.
  always_ff @(posedge clk) begin
    sha_q <= sha_d;
    shb_q <= shb_d;
  end

  assign bus.ready = ready;
  assign bus.done  = (state_q == FIN);
  assign bus.P     = res_q[1];
  assign bus.Q     = res_q[0];
  assign bus.mayor = mayor_q;
  assign bus.menor = menor_q;
  assign bus.igual = igual_q;

endmodule

// File: tb/tb_comparador_serial_id.sv
module tb_comparador_serial_id;

`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] pq;
    logic [2:0] fl;   // {mayor, menor, igual}
    int         lat;
    int         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_at_edge = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t sb8[$];
  exp_t sb5[$];
  int   acc8[$];
  int   acc5[$];
  exp_t held8;

  always #5 clk = ~clk;

  comparador_serial_id_if #(.N(8)) bus8 ();
  comparador_serial_id_if #(.N(5)) bus5 ();

  comparador_serial_id #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  comparador_serial_id #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (id %0d): got %0h expected %0h", name, id, act, exp);
    end
  endtask

  function automatic int model_lat(input int n, input int a, input int b);
    if (!EE) return n + 1;
    for (int i = n - 1; i >= 0; i--)
      if (a[i] != b[i]) return n - i + 1;
    return n + 1;
  endfunction

  function automatic exp_t model(input int n, input int a, input int b, input int id);
    exp_t e;
    if (a > b)      begin e.pq = 2'b10; e.fl = 3'b100; end
    else if (a < b) begin e.pq = 2'b00; e.fl = 3'b010; end
    else            begin e.pq = 2'b01; e.fl = 3'b001; end
    e.lat = model_lat(n, a, b);
    e.id  = id;
    return e;
  endfunction

  // Accepted starts are timestamped with the cycle number after the edge.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
    if (!rst_n) begin
      acc8.delete();
      acc5.delete();
    end else begin
      if (bus8.start && bus8.ready) acc8.push_back(cyc + 1);
      if (bus5.start && bus5.ready) acc5.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst_at_edge === 1'b0) begin
      held8 <= '{pq: 2'b01, fl: 3'b000, lat: 0, id: 0};
    end else if (bus8.done) begin
      if (sb8.size() == 0 || acc8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no pending request");
      end else begin
        e = sb8.pop_front();
        a = acc8.pop_front();
        chk("pq8",    e.id, {30'd0, bus8.P, bus8.Q}, {30'd0, e.pq});
        chk("flags8", e.id, {29'd0, bus8.mayor, bus8.menor, bus8.igual}, {29'd0, e.fl});
        chk("lat8",   e.id, cyc - a + 1, e.lat);
        held8 <= e;
      end
    end else begin
      chk("hold_pq8",    held8.id, {30'd0, bus8.P, bus8.Q}, {30'd0, held8.pq});
      chk("hold_flags8", held8.id, {29'd0, bus8.mayor, bus8.menor, bus8.igual}, {29'd0, held8.fl});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst_at_edge === 1'b1 && bus5.done) begin
      if (sb5.size() == 0 || acc5.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done5: got done=1 expected no pending request");
      end else begin
        e = sb5.pop_front();
        a = acc5.pop_front();
        chk("pq5",    e.id, {30'd0, bus5.P, bus5.Q}, {30'd0, e.pq});
        chk("flags5", e.id, {29'd0, bus5.mayor, bus5.menor, bus5.igual}, {29'd0, e.fl});
        chk("lat5",   e.id, cyc - a + 1, e.lat);
      end
    end
  end

  task automatic issue(input int n, input int a, input int b, input exp_t e);
    int w = 0;
    @(negedge clk);
    while (((n == 8) ? bus8.ready : bus5.ready) !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout (id %0d): got ready=0 expected 1 within 60 cycles", e.id);
      return;
    end
    if (n == 8) begin
      bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.start = 1'b1;
      sb8.push_back(e);
      @(negedge clk);
      bus8.start = 1'b0;
    end else begin
      bus5.A = a[4:0]; bus5.B = b[4:0]; bus5.start = 1'b1;
      sb5.push_back(e);
      @(negedge clk);
      bus5.start = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((sb8.size() != 0 || sb5.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", sb8.size(), sb5.size());
      sb8.delete();
      sb5.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int a, b;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
    bus5.start = 1'b0; bus5.A = '0; bus5.B = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 0, {31'd0, bus8.ready}, 1);
    chk("rst_done",  0, {31'd0, bus8.done},  0);
    chk("rst_pq",    0, {30'd0, bus8.P, bus8.Q}, 2'b01);
    chk("rst_flags", 0, {29'd0, bus8.mayor, bus8.menor, bus8.igual}, 0);
    chk("rst_ready5", 0, {31'd0, bus5.ready}, 1);

    // Directed vectors with hand-computed results
    issue(8, 8'h5A, 8'h5A, '{pq: 2'b01, fl: 3'b001, lat: 9, id: 1});
    issue(8, 8'h80, 8'h7F, '{pq: 2'b10, fl: 3'b100, lat: (EE ? 2 : 9), id: 2});
    issue(8, 8'h03, 8'h04, '{pq: 2'b00, fl: 3'b010, lat: (EE ? 7 : 9), id: 3});
    drain();

    // Back-to-back: menor first, start pulses in RUN ignored, then start held through FIN
    issue(8, 8'h03, 8'h04, '{pq: 2'b00, fl: 3'b010, lat: (EE ? 7 : 9), id: 4});
    chk("ready_in_run", 4, {31'd0, bus8.ready}, 0);
    bus8.A = 8'hFF; bus8.B = 8'h00; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.A = 8'h01; bus8.B = 8'h00; bus8.start = 1'b1;
    sb8.push_back('{pq: 2'b10, fl: 3'b100, lat: 9, id: 5});
    w = 0;
    while (bus8.done !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: got done=0 expected 1 within 40 cycles");
    end
    @(negedge clk);
    bus8.start = 1'b0;
    drain();

    // Reset mid-RUN aborts with no done
    bus8.A = 8'h5A; bus8.B = 8'h5A; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 6, {31'd0, bus8.ready}, 1);
    chk("abort_done",  6, {31'd0, bus8.done},  0);
    chk("abort_pq",    6, {30'd0, bus8.P, bus8.Q}, 2'b01);
    chk("abort_flags", 6, {29'd0, bus8.mayor, bus8.menor, bus8.igual}, 0);
    repeat (12) @(negedge clk);

    // Random sweeps, N=8 then N=5
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 8 == 0) ? a : $urandom_range(0, 255);
      issue(8, a, b, model(8, a, b, 1000 + i));
    end
    drain();
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 31);
      b = (i % 8 == 0) ? a : $urandom_range(0, 31);
      issue(5, a, b, model(5, a, b, 3000 + i));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comparador_serial_id.md
Name: comparador_serial_id

Overview:
- Sequential (bit-serial) version of the left-to-right iterative magnitude comparator network.
- Loads two N-bit words on a start strobe, then applies the typical-cell next-state function once per clock, MSB to LSB, starting from the initial state a = (p,q) = 01.
- Feeds the result-decoding/display stage downstream.
- Replaces the N-cell combinational chain with one cell, a counter and an FSM.

Parameters:
- N, 8, word width in bits (N >= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  load request; sampled only while ready = 1.
- A  input  N  word A; captured on an accepted start.
- B  input  N  word B; captured on an accepted start.
- ready  output  1  high when a start will be accepted.
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- P  output  1  final state variable p.
- Q  output  1  final state variable q.
- mayor  output  1  A > B.
- menor  output  1  A < B.
- igual  output  1  A == B.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. Only the rising edge of clk is used.
- State encoding (p,q):
  - 01 = equal so far (initial state a).
  - 10 = A greater.
  - 00 = A smaller.
  - 11 is illegal; the cell function maps 11 to 01.
- Cell function (absorbing once decided):
  - From 01: Ai > Bi gives 10; Ai < Bi gives 00; otherwise stays 01.
  - From 10: stays 10.
  - From 00: stays 00.
- FSM states:
  - IDLE: ready = 1. start = 1 captures A and B into shift registers, sets pq = 01 and cnt = N-1, and goes to RUN.
  - RUN: ready = 0. Each cycle, pq <= cell(pq, shA[N-1], shB[N-1]); shA and shB shift left, zero fill. If cnt == 0 go to FIN, else cnt <= cnt - 1.
  - FIN: lasts one cycle. done = 1, and the result registers are updated from pq. ready = 1. start = 1 here is accepted as in IDLE (back-to-back) and goes to RUN; otherwise go to IDLE.
- Latency: start accepted at edge t gives done high during the cycle after edge t+N, i.e. N+1 cycles from start to done.
- Result outputs:
  - P, Q, mayor, menor and igual are registered. They change only in the done cycle and hold until the next done.
  - Exactly one of mayor, menor and igual is 1 after the first completion.
- Reset values: ready = 1 once reset deasserts; done = 0; P = 0, Q = 1 (state a); mayor = 0, menor = 0, igual = 0; FSM = IDLE; cnt = 0.
- Reset mid-operation: rst_n = 0 in RUN or FIN aborts. There is no done pulse, and the results return to their reset values.
- start during RUN: ignored, not queued.
- A and B may change freely after capture; the result depends only on the captured values.
- cnt width: clog2(N).

Optional Feature:
- Macro: EARLY_EXIT_EN.
- Defined: in RUN, once the next pq is 10 or 00, go to FIN immediately. The decision is final because of MSB-first absorption. Latency becomes k+1 cycles, where k is the 1-based index of the first differing bit from the MSB. Equal words still take N+1 cycles.
- Undefined: always N+1 cycles. This gives fixed latency.
- Result values are identical in both builds.

Decomposition:
- Shared package comparador_pkg holds:
  - the state constants ST_IGUAL = 2'b01, ST_MAYOR = 2'b10, ST_MENOR = 2'b00;
  - the FSM state typedef (IDLE, RUN, FIN);
  - N_DEFAULT = 8.
- One natural sub-module: celda_tipica_fn. It is the combinational next-state function of one cell (inputs p, q, Ai, Bi; outputs P, Q) and is instantiated once in the RUN datapath.

Test Plan:
- N=8. A=8'h5A, B=8'h5A, start pulse -> done N+1 = 9 cycles later; P,Q = 01; igual = 1. Same count in both builds.
- A=8'h80, B=8'h7F -> mayor = 1, P,Q = 10. With EARLY_EXIT_EN, done 2 cycles after start; without it, 9.
- A=8'h03, B=8'h04 -> menor = 1, P,Q = 00. With EARLY_EXIT_EN, done 7 cycles after start (first difference at bit 2).
- Back-to-back: start held high through FIN with the second pair A=8'h01, B=8'h00 -> second done exactly 9 cycles after the first. Result changes from the first outcome to mayor only at the second done. start pulses during RUN are ignored.
- Reset mid-RUN: rst_n = 0 for 1 cycle at cycle 4 -> no done; outputs at reset values (P=0, Q=1, flags 0); ready = 1 the next cycle.
- Random sweep: 1000 random A/B pairs with N=8 and N=5 -> flags match A>B, A<B, A==B, and latency matches the build mode.
